// File: rtl/wb_io_ctrl.sv
// wb_io_ctrl: Wishbone-slave pad controller. It provides per-pad output and
// output-enable registers and a synchronised input view. It also detects edges
// on the inputs and merges them into a single level interrupt.
module wb_io_ctrl #(
  parameter int          NUM_IO      = 27,
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);

  localparam logic [5:0] OFS_OUT      = 6'd0;
  localparam logic [5:0] OFS_OEB      = 6'd1;
  localparam logic [5:0] OFS_IN       = 6'd2;
  localparam logic [5:0] OFS_IRQ_EN   = 6'd3;
  localparam logic [5:0] OFS_IRQ_STAT = 6'd4;
  localparam logic [5:0] OFS_EDGE_SEL = 6'd5;
  localparam logic [5:0] OFS_OUT_SET  = 6'd6;
  localparam logic [5:0] OFS_OUT_CLR  = 6'd7;

  // Edge detection stays off until the synchroniser and prev register hold real pad data.
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [NUM_IO-1:0] out_q;
  logic [NUM_IO-1:0] oeb_q;
  logic [NUM_IO-1:0] irq_en_q;
  logic [NUM_IO-1:0] irq_stat_q;
  logic [NUM_IO-1:0] edge_sel_q;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] prev_q;
  logic [2:0]        warm_q;

  logic              page_hit;
  logic              accept;
  logic              wr_acc;
  logic [5:0]        offset;
  logic [31:0]       sel_mask;
  logic [31:0]       rd_data;
  logic [NUM_IO-1:0] wr_mask;
  logic [NUM_IO-1:0] wr_bits;
  logic [NUM_IO-1:0] in_sync;
  logic [NUM_IO-1:0] rise;
  logic [NUM_IO-1:0] fall;
  logic [NUM_IO-1:0] edge_hit;
  logic [NUM_IO-1:0] stat_clr;
  logic              unused_bits;

  // An accepted access blocks the next cycle through the ack term, so a held strobe gets one ack every other cycle.
  assign page_hit = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign accept   = wbs_cyc_i & wbs_stb_i & page_hit & ~wbs_ack_o;
  assign wr_acc   = accept & wbs_we_i;
  assign offset   = wbs_adr_i[7:2];
  assign sel_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wr_mask  = sel_mask[NUM_IO-1:0];
  assign wr_bits  = wbs_dat_i[NUM_IO-1:0] & wr_mask;
  assign in_sync  = sync_q[SYNC_STAGES-1];

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i, sel_mask};

  assign io_out = out_q;
  assign io_oeb = oeb_q;

  // Read mux: bits above NUM_IO and unmapped or write-only offsets read as zero.
  always_comb begin
    rd_data = '0;
    case (offset)
      OFS_OUT:      rd_data[NUM_IO-1:0] = out_q;
      OFS_OEB:      rd_data[NUM_IO-1:0] = oeb_q;
      OFS_IN:       rd_data[NUM_IO-1:0] = in_sync;
      OFS_IRQ_EN:   rd_data[NUM_IO-1:0] = irq_en_q;
      OFS_IRQ_STAT: rd_data[NUM_IO-1:0] = irq_stat_q;
      OFS_EDGE_SEL: rd_data[NUM_IO-1:0] = edge_sel_q;
      default:      rd_data = '0;
    endcase
  end

  // Edge qualification per pad, plus the W1C clear mask from the current access.
  always_comb begin
    rise     = in_sync & ~prev_q;
    fall     = ~in_sync & prev_q;
    edge_hit = '0;
    stat_clr = '0;
    if (warm_q == WARM_DONE) begin
      edge_hit = (rise & edge_sel_q) | (fall & ~edge_sel_q);
    end
    if (wr_acc && (offset == OFS_IRQ_STAT)) begin
      stat_clr = wr_bits;
    end
  end

  // Input synchroniser chain, previous-value register and post-reset warm-up counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= in_sync;
      if (warm_q != WARM_DONE) begin
        warm_q <= warm_q + 3'd1;
      end
    end
  end

  // Bus handshake and register file. An edge set takes priority over a W1C clear on the same bit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      out_q      <= '0;
      oeb_q      <= '1;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      edge_sel_q <= '1;
    end else begin
      wbs_ack_o  <= accept;
      wbs_dat_o  <= accept ? rd_data : 32'h0;
      irq_stat_q <= (irq_stat_q & ~stat_clr) | edge_hit;
      if (wr_acc) begin
        case (offset)
          OFS_OUT:      out_q      <= (out_q & ~wr_mask) | wr_bits;
          OFS_OEB:      oeb_q      <= (oeb_q & ~wr_mask) | wr_bits;
          OFS_IRQ_EN:   irq_en_q   <= (irq_en_q & ~wr_mask) | wr_bits;
          OFS_EDGE_SEL: edge_sel_q <= (edge_sel_q & ~wr_mask) | wr_bits;
          OFS_OUT_SET:  out_q      <= out_q | wr_bits;
          OFS_OUT_CLR:  out_q      <= out_q & ~wr_bits;
          default:      ;
        endcase
      end
    end
  end

  // Registered interrupt line, one cycle behind the status and enable registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= |(irq_stat_q & irq_en_q);
    end
  end

endmodule
